seq_pattern_gen: RTL and testbench

//  Bit-serial pattern transmitter: the source side of the serial "seq" link whose sink is the

---
 rtl/seq_pattern_gen.sv | 189 ++++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: bit-serial pattern transmitter for the "seq" link.
// Shifts a PAT_W-bit pattern out MSB first, one bit per clock, repeats it
// repeat_cnt times with an optional idle gap between copies, and pulses
// done after the last bit. Every output comes straight from a flop.
module seq_pattern_gen #(
    parameter int   PAT_W    = 4,
    parameter int   CNT_W    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [CNT_W-1:0] gap_cycles,
    output logic             busy,
    output logic             seq_out,
    output logic             seq_valid,
    output logic             frame_start,
    output logic             done
);

    // Bit index counts PAT_W-1 down to 0 inside one copy of the pattern.
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Current-cycle state and the values latched at the accepted start.
    state_t           state;
    logic [PAT_W-1:0] pat;
    logic [CNT_W-1:0] gap_len;
    logic [CNT_W-1:0] rep_left;
    logic [CNT_W-1:0] gap_left;
    logic [IDX_W-1:0] bit_idx;

    // Next-cycle values produced by the combinational process.
    state_t           state_nxt;
    logic [PAT_W-1:0] pat_nxt;
    logic [CNT_W-1:0] gap_len_nxt;
    logic [CNT_W-1:0] rep_left_nxt;
    logic [CNT_W-1:0] gap_left_nxt;
    logic [IDX_W-1:0] bit_idx_nxt;

    logic             busy_nxt;
    logic             seq_out_nxt;
    logic             seq_valid_nxt;
    logic             frame_start_nxt;
    logic             done_nxt;

    // A new request is taken whenever the transmitter is not busy; this
    // includes the DONE cycle so back-to-back transfers lose no clock.
    logic accept;
    assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

    // Last bit of a copy is on the line this cycle.
    logic last_bit;
    assign last_bit = (state == ST_SEND) && (bit_idx == '0);

    // Final copy just finished: rep_left is about to reach zero.
    logic last_copy;
    assign last_copy = (rep_left == CNT_W'(1));

    // Next-state and next-counter logic for the transmit FSM.
    always_comb begin
        state_nxt    = state;
        pat_nxt      = pat;
        gap_len_nxt  = gap_len;
        rep_left_nxt = rep_left;
        gap_left_nxt = gap_left;
        bit_idx_nxt  = bit_idx;

        case (state)
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    pat_nxt      = pattern_in;
                    gap_len_nxt  = gap_cycles;
                    rep_left_nxt = repeat_cnt;
                    bit_idx_nxt  = MSB_IDX;
                    if (repeat_cnt == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_SEND;
                    end
                end
            end

            ST_SEND: begin
                if (last_bit) begin
                    rep_left_nxt = rep_left - CNT_W'(1);
                    if (last_copy) begin
                        state_nxt = ST_DONE;
                    end else if (gap_len == '0) begin
                        // Next copy follows immediately, no idle bubble.
                        state_nxt   = ST_SEND;
                        bit_idx_nxt = MSB_IDX;
                    end else begin
                        // gap_left counts the remaining gap cycles minus one,
                        // so the GAP state lasts exactly gap_len cycles.
                        state_nxt    = ST_GAP;
                        gap_left_nxt = gap_len - CNT_W'(1);
                    end
                end else begin
                    bit_idx_nxt = bit_idx - IDX_W'(1);
                end
            end

            ST_GAP: begin
                if (gap_left == '0) begin
                    state_nxt   = ST_SEND;
                    bit_idx_nxt = MSB_IDX;
                end else begin
                    gap_left_nxt = gap_left - CNT_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        busy_nxt        = 1'b0;
        seq_out_nxt     = IDLE_BIT;
        seq_valid_nxt   = 1'b0;
        frame_start_nxt = 1'b0;
        done_nxt        = 1'b0;

        case (state_nxt)
            ST_SEND: begin
                busy_nxt        = 1'b1;
                seq_out_nxt     = pat_nxt[bit_idx_nxt];
                seq_valid_nxt   = 1'b1;
                frame_start_nxt = (bit_idx_nxt == MSB_IDX);
            end
            ST_GAP: begin
                busy_nxt = 1'b1;
            end
            ST_DONE: begin
                done_nxt = 1'b1;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Control state and registered outputs; reset wins over start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            rep_left    <= '0;
            gap_left    <= '0;
            bit_idx     <= '0;
            busy        <= 1'b0;
            seq_out     <= IDLE_BIT;
            seq_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            rep_left    <= rep_left_nxt;
            gap_left    <= gap_left_nxt;
            bit_idx     <= bit_idx_nxt;
            busy        <= busy_nxt;
            seq_out     <= seq_out_nxt;
            seq_valid   <= seq_valid_nxt;
            frame_start <= frame_start_nxt;
            done        <= done_nxt;
        end
    end

    // Latched transfer data; only meaningful while a transfer is active,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        pat     <= pat_nxt;
        gap_len <= gap_len_nxt;
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: self-checking bench for seq_pattern_gen.
// A queue-based reference model expands every accepted request into the
// full list of per-cycle output values, which are compared each cycle.
module tb_seq_pattern_gen;

    localparam int   PAT_W    = 4;
    localparam int   CNT_W    = 8;
    localparam logic IDLE_BIT = 1'b0;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [PAT_W-1:0] pattern_in;
    logic [CNT_W-1:0] repeat_cnt;
    logic [CNT_W-1:0] gap_cycles;
    logic             busy;
    logic             seq_out;
    logic             seq_valid;
    logic             frame_start;
    logic             done;

    seq_pattern_gen #(
        .PAT_W   (PAT_W),
        .CNT_W   (CNT_W),
        .IDLE_BIT(IDLE_BIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pattern_in (pattern_in),
        .repeat_cnt (repeat_cnt),
        .gap_cycles (gap_cycles),
        .busy       (busy),
        .seq_out    (seq_out),
        .seq_valid  (seq_valid),
        .frame_start(frame_start),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected outputs packed as {busy, seq_out, seq_valid, frame_start, done}.
    localparam logic [4:0] IDLE_V = {1'b0, IDLE_BIT, 3'b000};
    logic [4:0] exp_q[$];
    logic [4:0] exp_cur = IDLE_V;

    task automatic check_out(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, expv, $time);
        end
    endtask

    // Expand one accepted request into its cycle-by-cycle output list.
    task automatic push_transfer(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r,
                                 input logic [CNT_W-1:0] g);
        for (int c = 0; c < int'(r); c++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                exp_q.push_back({1'b1, p[b], 1'b1, (b == PAT_W - 1), 1'b0});
            if (c < int'(r) - 1)
                for (int k = 0; k < int'(g); k++)
                    exp_q.push_back({1'b1, IDLE_BIT, 3'b000});
        end
        exp_q.push_back({1'b0, IDLE_BIT, 3'b001});
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then compare.
    task automatic step(input string tag, input logic rst, input logic st,
                        input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r,
                        input logic [CNT_W-1:0] g);
        reset      = rst;
        start      = st;
        pattern_in = p;
        repeat_cnt = r;
        gap_cycles = g;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_cur = IDLE_V;
        end else begin
            if (st && !exp_cur[4]) push_transfer(p, r, g);
            exp_cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
        end
        #1;
        check_out(tag, 32'({busy, seq_out, seq_valid, frame_start, done}), 32'(exp_cur));
    endtask

    task automatic idle_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 4'h0, 8'd0, 8'd0);
    endtask

    logic [3:0] bits;
    int         busy_seen;

    initial begin
        // Reset state.
        step("reset", 1'b1, 1'b0, 4'h0, 8'd0, 8'd0);
        step("reset", 1'b1, 1'b1, 4'hF, 8'd3, 8'd1);
        idle_steps("idle", 2);

        // Single copy of 1011: bits c1..c4, done c5.
        step("t1", 1'b0, 1'b1, 4'b1011, 8'd1, 8'd0);
        bits = {bits[2:0], seq_out};
        for (int i = 0; i < 3; i++) begin
            step("t1", 1'b0, 1'b0, 4'h0, 8'd0, 8'd0);
            bits = {bits[2:0], seq_out};
        end
        check_out("t1_bits", 32'(bits), 32'h0000000B);
        step("t1", 1'b0, 1'b0, 4'h0, 8'd0, 8'd0);
        check_out("t1_done", 32'(done), 32'd1);
        idle_steps("t1", 2);

        // Two copies back to back, then two copies with a 3-cycle gap.
        step("t2", 1'b0, 1'b1, 4'b1011, 8'd2, 8'd0);
        idle_steps("t2", 10);
        step("t3", 1'b0, 1'b1, 4'b1011, 8'd2, 8'd3);
        idle_steps("t3", 13);

        // repeat_cnt of zero: only a done pulse, busy never rises.
        busy_seen = 0;
        step("t4", 1'b0, 1'b1, 4'hA, 8'd0, 8'd2);
        check_out("t4_done", 32'(done), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step("t4", 1'b0, 1'b0, 4'h0, 8'd0, 8'd0);
            if (busy || seq_valid) busy_seen++;
        end
        check_out("t4_quiet", 32'(busy_seen), 32'd0);

        // Start during a transfer is ignored; start in the done cycle is taken.
        step("t5", 1'b0, 1'b1, 4'b1011, 8'd2, 8'd0);
        step("t5", 1'b0, 1'b0, 4'h0, 8'd0, 8'd0);
        step("t5", 1'b0, 1'b1, 4'b0100, 8'd5, 8'd2);
        for (int i = 0; i < 6; i++) step("t5", 1'b0, 1'b0, 4'h0, 8'd0, 8'd0);
        check_out("t5_done", 32'(done), 32'd1);
        step("t5b", 1'b0, 1'b1, 4'b1100, 8'd1, 8'd0);
        check_out("t5_msb", 32'({seq_out, frame_start, busy}), 32'b111);
        idle_steps("t5b", 6);

        // Reset mid-transfer: no done pulse; then a clean single transfer.
        step("t6", 1'b0, 1'b1, 4'b1011, 8'd2, 8'd0);
        idle_steps("t6", 2);
        step("t6_rst", 1'b1, 1'b0, 4'h0, 8'd0, 8'd0);
        idle_steps("t6", 3);
        step("t6b", 1'b0, 1'b1, 4'b1011, 8'd1, 8'd0);
        idle_steps("t6b", 6);
        step("t6_rs", 1'b1, 1'b1, 4'b1111, 8'd1, 8'd0);
        idle_steps("t6_rs", 3);

        // Counter extremes: maximum repeat count and maximum gap.
        step("maxrep", 1'b0, 1'b1, 4'b1001, 8'd255, 8'd0);
        idle_steps("maxrep", 1025);
        step("maxgap", 1'b0, 1'b1, 4'b0110, 8'd2, 8'd255);
        idle_steps("maxgap", 270);

        // Randomized traffic with changing inputs and occasional resets.
        for (int i = 0; i < 2500; i++) begin
            step("rand", ($urandom_range(0, 119) == 0), ($urandom_range(0, 3) == 0),
                 4'($urandom), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 3)));
        end
        idle_steps("drain", 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
